// File: rtl/arbitech_exec_slice.sv
// Execute slice of the 19-bit arbitech CPU: field decode, combinational ALU,
// and a word-addressed data memory with a registered load port.
module arbitech_exec_slice #(
  parameter int WIDTH     = 19,
  parameter int ADDR_BITS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] instruction,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [3:0]       opcode,
  output logic [3:0]       rd,
  output logic [3:0]       rs1,
  output logic [3:0]       rs2,
  output logic [WIDTH-1:0] imm,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic             mem_read,
  output logic             mem_write,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_rdata
);

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_MUL   = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_INC   = 4'b0100;
  localparam logic [3:0] OP_DEC   = 4'b0101;
  localparam logic [3:0] OP_AND   = 4'b0110;
  localparam logic [3:0] OP_OR    = 4'b0111;
  localparam logic [3:0] OP_XOR   = 4'b1000;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_LOAD  = 4'b1010;
  localparam logic [3:0] OP_STORE = 4'b1011;

  logic [WIDTH-1:0]     mem [2**ADDR_BITS];
  logic [ADDR_BITS-1:0] idx;

  assign opcode    = instruction[18:15];
  assign rd        = instruction[14:11];
  assign rs1       = instruction[10:7];
  assign rs2       = instruction[6:3];
  assign imm       = {{(WIDTH-11){1'b0}}, instruction[10:0]};
  assign mem_read  = (opcode == OP_LOAD);
  assign mem_write = (opcode == OP_STORE);
  assign mem_addr  = op_a + imm;
  assign idx       = mem_addr[ADDR_BITS-1:0];
  assign zero      = (alu_result == '0);

  always_comb begin
    alu_result = mem_addr;
    case (opcode)
      OP_ADD: alu_result = op_a + op_b;
      OP_SUB: alu_result = op_a - op_b;
      OP_MUL: alu_result = op_a * op_b;
      // Divide-by-zero saturates to all ones rather than producing X.
      OP_DIV: alu_result = (op_b == '0) ? '1 : op_a / op_b;
      OP_INC: alu_result = op_a + WIDTH'(1);
      OP_DEC: alu_result = op_a - WIDTH'(1);
      OP_AND: alu_result = op_a & op_b;
      OP_OR:  alu_result = op_a | op_b;
      OP_XOR: alu_result = op_a ^ op_b;
      OP_NOT: alu_result = ~op_a;
      default: alu_result = mem_addr;
    endcase
  end

  // Array has no reset; writes are simply gated off while reset is held.
  always_ff @(posedge clk) begin
    if (reset && mem_write) mem[idx] <= op_b;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        mem_rdata <= '0;
    else if (mem_read) mem_rdata <= mem[idx];
  end

endmodule

// File: tb/tb_arbitech_exec_slice.sv
// Directed bench for arbitech_exec_slice: decode, ALU sweep and edges,
// memory store/load, address aliasing and asynchronous reset behaviour.
module tb_arbitech_exec_slice;

  logic        clk = 1'b0;
  logic        reset;
  logic [18:0] instruction, op_a, op_b;
  logic [3:0]  opcode, rd, rs1, rs2;
  logic [18:0] imm, alu_result, mem_addr, mem_rdata;
  logic        zero, mem_read, mem_write;

  int checks = 0;
  int errors = 0;

  arbitech_exec_slice dut (
    .clk(clk), .reset(reset), .instruction(instruction), .op_a(op_a), .op_b(op_b),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .alu_result(alu_result), .zero(zero), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [18:0] obs, input logic [18:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [18:0] a, input logic [18:0] b);
    instruction = {op, 15'b0};
    op_a = a;
    op_b = b;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  logic [3:0]  t_op  [13] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9,
                              4'd1, 4'd3, 4'd2};
  logic [18:0] t_a   [13] = '{19'd10, 19'd20, 19'd3, 19'd20, 19'd5, 19'd5, 19'd5, 19'd5, 19'd5, 19'd5,
                              19'd0, 19'd7, 19'h40000};
  logic [18:0] t_b   [13] = '{19'd20, 19'd10, 19'd4, 19'd4, 19'd99, 19'd99, 19'd3, 19'd3, 19'd3, 19'd77,
                              19'd1, 19'd0, 19'd2};
  logic [18:0] t_exp [13] = '{19'd30, 19'd10, 19'd12, 19'd5, 19'd6, 19'd4, 19'd1, 19'd7, 19'd6, 19'h7FFFA,
                              19'h7FFFF, 19'h7FFFF, 19'd0};

  initial begin
    reset = 1'b0;
    drive(4'd0, 19'd0, 19'd0);
    #2;
    chk("rst_rdata", mem_rdata, 19'd0);
    @(negedge clk);
    reset = 1'b1;

    // Decode
    instruction = 19'b0001_0001_0001_0001_000;
    #1;
    chk("dec_opcode", {15'b0, opcode}, 19'd1);
    chk("dec_rd", {15'b0, rd}, 19'd1);
    chk("dec_rs1", {15'b0, rs1}, 19'd1);
    chk("dec_rs2", {15'b0, rs2}, 19'd1);
    chk("dec_imm", imm, 19'h088);

    // ALU sweep and edges
    for (int i = 0; i < 13; i++) begin
      drive(t_op[i], t_a[i], t_b[i]);
      #1;
      chk($sformatf("alu_%0d", i), alu_result, t_exp[i]);
    end
    chk("mul_zero_flag", {18'b0, zero}, 19'd1);
    drive(4'd4, 19'h7FFFF, 19'd0); #1; chk("inc_wrap", alu_result, 19'd0);
    drive(4'd5, 19'd0, 19'd0);     #1; chk("dec_wrap", alu_result, 19'h7FFFF);
    chk("dec_zero_flag", {18'b0, zero}, 19'd0);
    instruction = {4'b1100, 15'h0005}; op_a = 19'd100; #1;
    chk("op_c_addr", alu_result, 19'd105);

    // Store then load
    @(negedge clk);
    drive(4'b1011, 19'd0, 19'd42);
    #1;
    chk("st_mem_write", {18'b0, mem_write}, 19'd1);
    chk("st_mem_read", {18'b0, mem_read}, 19'd0);
    step;
    chk("st_rdata_hold", mem_rdata, 19'd0);
    @(negedge clk);
    drive(4'b1010, 19'd0, 19'd0);
    step;
    chk("ld_42", mem_rdata, 19'd42);

    // Aliasing: 1024 maps onto index 0
    @(negedge clk);
    drive(4'b1011, 19'd1024, 19'd77);
    #1;
    chk("alias_addr", mem_addr, 19'd1024);
    step;
    @(negedge clk);
    drive(4'b1010, 19'd0, 19'd0);
    step;
    chk("alias_ld", mem_rdata, 19'd77);
    @(negedge clk);
    drive(4'd0, 19'd1, 19'd1);
    step;
    chk("rdata_hold", mem_rdata, 19'd77);

    // Async reset mid-cycle, store blocked while in reset
    @(negedge clk);
    drive(4'b1010, 19'd0, 19'd0);
    step;
    chk("pre_rst_ld", mem_rdata, 19'd77);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst", mem_rdata, 19'd0);
    @(negedge clk);
    drive(4'b1011, 19'd0, 19'd555);
    #1;
    chk("rst_comb_wr", {18'b0, mem_write}, 19'd1);
    chk("rst_comb_addr", alu_result, 19'd0);
    step;
    step;
    @(negedge clk);
    reset = 1'b1;
    drive(4'b1010, 19'd0, 19'd0);
    step;
    chk("rst_store_blocked", mem_rdata, 19'd77);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
